// File: rtl/spi_boot_loader.sv
// SPI-slave boot loader: writes/reads external SRAM from SPI frames, then hands the SRAM bus to the Atom.
// Latency: SPI pins seen 2-3 clk late; each SRAM access takes WE_CYCLES clk plus setup/hold.
// Backpressure: none. SCK must stay at or below clk/4. BOOT_CHECKSUM_EN adds a write checksum (cmd 0x05).
module spi_boot_loader #(
    parameter int ADDR_W    = 18,
    parameter int WE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              SCK,
    input  logic              SSEL,
    input  logic              MOSI,
    output logic              MISO,
    output logic              booting,
    output logic              progress,
    input  logic              atom_RAMCS_b,
    input  logic              atom_RAMOE_b,
    input  logic              atom_RAMWE_b,
    input  logic [ADDR_W-1:0] atom_RAMA,
    input  logic [7:0]        atom_RAMDin,
    output logic              ext_RAMCS_b,
    output logic              ext_RAMOE_b,
    output logic              ext_RAMWE_b,
    output logic [ADDR_W-1:0] ext_RAMA,
    output logic [7:0]        ext_RAMDin,
    input  logic [7:0]        ext_RAMDout
);
    typedef enum logic [3:0] {IDLE, CMD, ADDR, WDATA, WPULSE, RFETCH, RDATA, SKIP, DONE} state_t;

    localparam logic [3:0] WE_LEN = 4'(WE_CYCLES);

    state_t              state, state_nxt;
    logic [2:0]          sck_s, ssel_s;
    logic [1:0]          mosi_s;
    logic                sck_rise, sck_fall, ssel_rise, ssel_fall, ssel_act;
    logic [2:0]          bit_cnt;
    logic [6:0]          rx_sh;
    logic                byte_vld;
    logic [7:0]          rx_byte;
    logic [ADDR_W-1:0]   addr;
    logic [ADDR_W+7:0]   addr_sh;
    logic [1:0]          addr_cnt;
    logic                is_rd, rel_pend;
    logic [3:0]          pcnt;
    logic                pulse_end;
    logic [7:0]          wdat, rd_buf, tx_sh;
    logic                miso_q, boot_we_b, boot_oe_b;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            sck_s  <= 3'b000;
            ssel_s <= 3'b111;
            mosi_s <= 2'b00;
        end else begin
            sck_s  <= {sck_s[1:0], SCK};
            ssel_s <= {ssel_s[1:0], SSEL};
            mosi_s <= {mosi_s[0], MOSI};
        end
    end

    // Stage 1 of SCK/SSEL lines up with stage 1 of MOSI; stage 2 is only for edge detection.
    assign sck_rise  = sck_s[1] & ~sck_s[2];
    assign sck_fall  = ~sck_s[1] & sck_s[2];
    assign ssel_rise = ssel_s[1] & ~ssel_s[2];
    assign ssel_fall = ~ssel_s[1] & ssel_s[2];
    assign ssel_act  = ~ssel_s[1];
    assign rx_byte   = {rx_sh, mosi_s[1]};
    assign byte_vld  = sck_rise & ssel_act & (bit_cnt == 3'd7) & (state != DONE);
    assign addr_sh   = {addr, rx_byte};
    assign pulse_end = ((state == WPULSE) && (pcnt == WE_LEN + 4'd1)) ||
                       ((state == RFETCH) && (pcnt == WE_LEN));

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            bit_cnt  <= 3'd0;
            rx_sh    <= 7'd0;
            progress <= 1'b0;
        end else begin
            progress <= byte_vld;
            if (!ssel_act || ssel_fall) begin
                bit_cnt <= 3'd0;
            end else if (sck_rise) begin
                bit_cnt <= bit_cnt + 3'd1;
                rx_sh   <= {rx_sh[5:0], mosi_s[1]};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (ssel_fall) state_nxt = CMD;
            CMD:    if (byte_vld) begin
                        case (rx_byte)
                            8'h02, 8'h03: state_nxt = ADDR;
                            default:      state_nxt = SKIP;
                        endcase
                    end
            ADDR:   if (byte_vld && addr_cnt == 2'd2) state_nxt = is_rd ? RFETCH : WDATA;
            WDATA:  if (byte_vld) state_nxt = WPULSE;
            WPULSE: if (pulse_end) state_nxt = ssel_act ? WDATA : IDLE;
            RFETCH: if (pulse_end) state_nxt = ssel_act ? RDATA : IDLE;
            RDATA:  if (byte_vld) state_nxt = RFETCH;
            SKIP:   state_nxt = SKIP;
            DONE:   state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
        // SRAM strobes in flight finish first; they drop to IDLE on their own when SSEL is gone.
        if (ssel_rise && (state inside {CMD, ADDR, WDATA, RDATA, SKIP}))
            state_nxt = rel_pend ? DONE : IDLE;
    end

`ifdef BOOT_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b)                        csum <= 8'd0;
        else if (state == WDATA && byte_vld) csum <= csum + rx_byte;
    end
`endif

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            addr      <= '0;
            addr_cnt  <= 2'd0;
            is_rd     <= 1'b0;
            rel_pend  <= 1'b0;
            pcnt      <= 4'd0;
            wdat      <= 8'd0;
            rd_buf    <= 8'hFF;
            tx_sh     <= 8'hFF;
            miso_q    <= 1'b1;
            boot_we_b <= 1'b1;
            boot_oe_b <= 1'b1;
        end else begin
            if ((state inside {WPULSE, RFETCH}) && state_nxt == state) pcnt <= pcnt + 4'd1;
            else                                                      pcnt <= 4'd0;

            if (state == CMD && byte_vld) begin
                addr_cnt <= 2'd0;
                is_rd    <= (rx_byte == 8'h03);
                rel_pend <= (rx_byte == 8'hA5);
            end
            if (state == ADDR && byte_vld) begin
                addr     <= addr_sh[ADDR_W-1:0];
                addr_cnt <= addr_cnt + 2'd1;
            end
            if (state == WDATA && byte_vld) wdat <= rx_byte;

            // Write: one setup clk, WE_CYCLES low, one hold clk, then advance.
            if (state == WPULSE) begin
                if (pcnt == 4'd0)         boot_we_b <= 1'b0;
                if (pcnt == WE_LEN)       boot_we_b <= 1'b1;
                if (pcnt == WE_LEN + 4'd1) addr     <= addr + ADDR_W'(1);
            end
            if (state == RFETCH) begin
                if (pcnt == 4'd0) boot_oe_b <= 1'b0;
                if (pcnt == WE_LEN) begin
                    boot_oe_b <= 1'b1;
                    rd_buf    <= ext_RAMDout;
                    addr      <= addr + ADDR_W'(1);
                end
            end

            // Fetched data goes out one byte after it was fetched, so the first read byte is 0xFF.
            if (ssel_fall) begin
                tx_sh  <= 8'hFF;
                miso_q <= 1'b1;
            end else if (byte_vld) begin
                tx_sh <= (state == RDATA) ? rd_buf : 8'hFF;
`ifdef BOOT_CHECKSUM_EN
                if (state == CMD && rx_byte == 8'h05) tx_sh <= csum;
`endif
            end else if (sck_fall) begin
                miso_q <= tx_sh[7];
                tx_sh  <= {tx_sh[6:0], 1'b1};
            end
        end
    end

    assign MISO        = ssel_act ? miso_q : 1'b1;
    assign booting     = (state != DONE);
    assign ext_RAMCS_b = booting ? 1'b0      : atom_RAMCS_b;
    assign ext_RAMOE_b = booting ? boot_oe_b : atom_RAMOE_b;
    assign ext_RAMWE_b = booting ? boot_we_b : atom_RAMWE_b;
    assign ext_RAMA    = booting ? addr      : atom_RAMA;
    assign ext_RAMDin  = booting ? wdat      : atom_RAMDin;
endmodule

// File: tb/tb_spi_boot_loader.sv
// Bench for spi_boot_loader: SPI master stimulus, SRAM model, scoreboards for writes and MISO bytes.
module tb_spi_boot_loader;
    localparam int ADDR_W    = 18;
    localparam int WE_CYCLES = 2;
    localparam int HALF      = 50;

    logic              clk = 1'b0;
    logic              reset_b, SCK, SSEL, MOSI, MISO, booting, progress;
    logic              atom_RAMCS_b, atom_RAMOE_b, atom_RAMWE_b;
    logic [ADDR_W-1:0] atom_RAMA;
    logic [7:0]        atom_RAMDin;
    logic              ext_RAMCS_b, ext_RAMOE_b, ext_RAMWE_b;
    logic [ADDR_W-1:0] ext_RAMA;
    logic [7:0]        ext_RAMDin, ext_RAMDout;

    logic [7:0]        mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W+7:0] exp_wr [$];
    logic [7:0]        exp_miso [$];
    int errors = 0, checks = 0;
    int we_pulses = 0, oe_pulses = 0, prog_cnt = 0, late_we = 0;

    always #5 clk = ~clk;

    spi_boot_loader #(.ADDR_W(ADDR_W), .WE_CYCLES(WE_CYCLES)) dut (
        .clk(clk), .reset_b(reset_b), .SCK(SCK), .SSEL(SSEL), .MOSI(MOSI), .MISO(MISO),
        .booting(booting), .progress(progress),
        .atom_RAMCS_b(atom_RAMCS_b), .atom_RAMOE_b(atom_RAMOE_b), .atom_RAMWE_b(atom_RAMWE_b),
        .atom_RAMA(atom_RAMA), .atom_RAMDin(atom_RAMDin),
        .ext_RAMCS_b(ext_RAMCS_b), .ext_RAMOE_b(ext_RAMOE_b), .ext_RAMWE_b(ext_RAMWE_b),
        .ext_RAMA(ext_RAMA), .ext_RAMDin(ext_RAMDin), .ext_RAMDout(ext_RAMDout)
    );

    assign ext_RAMDout = mem[ext_RAMA];
    always @(posedge clk) if (!ext_RAMCS_b && !ext_RAMWE_b) mem[ext_RAMA] <= ext_RAMDin;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write/read strobe monitor: pulse width, data setup/hold, and write scoreboard.
    logic              we_q = 1'b1, oe_q = 1'b1, prog_q = 1'b0;
    logic [7:0]        din_q = 8'd0;
    int                we_len = 0, oe_len = 0;
    logic [ADDR_W+7:0] e;
    always @(negedge clk) begin
        if (reset_b && booting) begin
            if (!ext_RAMWE_b) begin
                if (we_q) we_pulses++;
                we_len = we_q ? 1 : we_len + 1;
                chk("we_din_stable", ext_RAMDin, din_q);
            end else if (!we_q) begin
                chk("we_len", we_len, WE_CYCLES);
                chk("we_din_hold", ext_RAMDin, din_q);
                if (exp_wr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: addr %0h data %0h, none expected", ext_RAMA, ext_RAMDin);
                end else begin
                    e = exp_wr.pop_front();
                    chk("wr_addr", ext_RAMA, e[ADDR_W+7:8]);
                    chk("wr_data", ext_RAMDin, e[7:0]);
                end
            end
            if (!ext_RAMOE_b) begin
                if (oe_q) oe_pulses++;
                oe_len = oe_q ? 1 : oe_len + 1;
            end else if (!oe_q) begin
                chk("oe_len", oe_len, WE_CYCLES);
            end
            we_q = ext_RAMWE_b;
            oe_q = ext_RAMOE_b;
        end else begin
            we_q = 1'b1;
            oe_q = 1'b1;
            if (!ext_RAMWE_b && !booting) late_we++;
        end
        din_q = ext_RAMDin;
        if (progress) begin
            prog_cnt++;
            chk("progress_width", prog_q, 1'b0);
        end
        prog_q = progress;
    end

    // MISO monitor: deserialise on SCK rise, compare each full byte with the scoreboard.
    logic [7:0] m_sh = 8'd0;
    int         m_cnt = 0;
    always @(negedge SSEL) m_cnt = 0;
    always @(posedge SCK) begin
        if (!SSEL) begin
            m_sh = {m_sh[6:0], MISO};
            m_cnt++;
            if (m_cnt == 8) begin
                m_cnt = 0;
                if (exp_miso.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_miso: got %0h, none expected", m_sh);
                end else begin
                    chk("miso_byte", m_sh, exp_miso.pop_front());
                end
            end
        end
    end

    task automatic spi_bit(input logic b);
        MOSI = b;
        #HALF SCK = 1'b1;
        #HALF SCK = 1'b0;
    endtask

    // tx/mexp hold n bytes, first byte in the most significant position used.
    task automatic spi_frame(input string name, input logic [63:0] tx, input logic [63:0] mexp,
                             input int n, input int part, input int nwe, input int noe, input int nprog);
        int we0, oe0, p0;
        logic [7:0] b;
        we0 = we_pulses; oe0 = oe_pulses; p0 = prog_cnt;
        for (int i = 0; i < n; i++) exp_miso.push_back(mexp[8*(n-1-i) +: 8]);
        SSEL = 1'b0;
        #100;
        for (int i = 0; i < n; i++) begin
            b = tx[8*(n-1-i) +: 8];
            for (int k = 7; k >= 0; k--) spi_bit(b[k]);
        end
        b = 8'h77;
        for (int k = 0; k < part; k++) spi_bit(b[7-k]);
        #100 SSEL = 1'b1;
        #300;
        chk({name, "_we_pulses"}, we_pulses - we0, nwe);
        chk({name, "_oe_pulses"}, oe_pulses - oe0, noe);
        chk({name, "_progress"}, prog_cnt - p0, nprog);
    endtask

    task automatic reset_check(input string name);
        reset_b = 1'b0;
        #20;
        chk({name, "_booting"}, booting, 1'b1);
        chk({name, "_miso"}, MISO, 1'b1);
        chk({name, "_we"}, ext_RAMWE_b, 1'b1);
        chk({name, "_oe"}, ext_RAMOE_b, 1'b1);
        chk({name, "_cs"}, ext_RAMCS_b, 1'b0);
        chk({name, "_addr"}, ext_RAMA, 0);
        chk({name, "_progress"}, progress, 1'b0);
        reset_b = 1'b1;
    endtask

    initial begin
        reset_b = 1'b0; SCK = 1'b0; SSEL = 1'b1; MOSI = 1'b0;
        atom_RAMCS_b = 1'b1; atom_RAMOE_b = 1'b1; atom_RAMWE_b = 1'b1;
        atom_RAMA = '0; atom_RAMDin = 8'd0;
        @(posedge clk);
        #3;
        reset_check("rst");
        #40;

        exp_wr.push_back({18'h0C000, 8'hAA});
        exp_wr.push_back({18'h0C001, 8'h55});
        spi_frame("wr1", 64'h0200C000AA55, 64'hFFFFFFFFFFFF, 6, 0, 2, 0, 6);
        chk("mem_0C000", mem[18'h0C000], 8'hAA);
        chk("mem_0C001", mem[18'h0C001], 8'h55);
        spi_frame("rd1", 64'h0300C000000000, 64'hFFFFFFFFFFAA55, 7, 0, 0, 4, 7);

        exp_wr.push_back({18'h3FFFF, 8'h11});
        exp_wr.push_back({18'h00000, 8'h22});
        spi_frame("wrap", 64'h0203FFFF1122, 64'hFFFFFFFFFFFF, 6, 0, 2, 0, 6);
        chk("mem_00000", mem[18'h00000], 8'h22);
        spi_frame("rdwrap", 64'h0303FFFF000000, 64'hFFFFFFFFFF1122, 7, 0, 0, 4, 7);

        spi_frame("partial", 64'h02000100, 64'hFFFFFFFF, 4, 4, 0, 0, 4);
        exp_wr.push_back({18'h00100, 8'h33});
        spi_frame("after", 64'h0200010033, 64'hFFFFFFFFFF, 5, 0, 1, 0, 5);
        spi_frame("rd100", 64'h030001000000, 64'hFFFFFFFFFF33, 6, 0, 0, 3, 6);

        spi_frame("unknown", 64'h5A010203, 64'hFFFFFFFF, 4, 0, 0, 0, 4);

`ifdef BOOT_CHECKSUM_EN
        reset_check("rst2");
        #40;
        exp_wr.push_back({18'h00010, 8'h10});
        exp_wr.push_back({18'h00011, 8'h20});
        exp_wr.push_back({18'h00012, 8'hF0});
        spi_frame("cswr", 64'h020000101020F0, 64'hFFFFFFFFFFFFFF, 7, 0, 3, 0, 7);
        spi_frame("csum", 64'h0500, 64'hFF20, 2, 0, 0, 0, 2);
`else
        spi_frame("cmd05", 64'h0500, 64'hFFFF, 2, 0, 0, 0, 2);
`endif

        spi_frame("release", 64'hA5, 64'hFF, 1, 0, 0, 0, 1);
        chk("booting_after_release", booting, 1'b0);
        atom_RAMA = 18'h12345; atom_RAMOE_b = 1'b0; atom_RAMDin = 8'h5C;
        #20;
        chk("pass_rama", ext_RAMA, 18'h12345);
        chk("pass_cs", ext_RAMCS_b, 1'b1);
        chk("pass_oe", ext_RAMOE_b, 1'b0);
        chk("pass_din", ext_RAMDin, 8'h5C);
        atom_RAMA = 18'h00ABC; atom_RAMOE_b = 1'b1;
        #20;
        chk("pass_rama2", ext_RAMA, 18'h00ABC);
        chk("pass_oe2", ext_RAMOE_b, 1'b1);

        atom_RAMA = '0; atom_RAMCS_b = 1'b0;
        spi_frame("done_ignored", 64'h0200000099, 64'hFFFFFFFFFF, 5, 0, 0, 0, 0);
        chk("done_no_we", late_we, 0);
        chk("done_mem0", mem[18'h00000], 8'h22);
        chk("done_booting", booting, 1'b0);

        chk("wr_queue_drained", exp_wr.size(), 0);
        chk("miso_queue_drained", exp_miso.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
